// File: rtl/pc_fetch_sequencer.sv
// PC sequencer: BOOT/FETCH/EXEC/TRAP control for a single-cycle core with mepc/mcause trap state.
// Optional retired-instruction counter is enabled by defining PC_SEQ_INSTRET_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_pc,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic        i_imem_err,
    output logic        o_instr_valid,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_illegal,
    input  logic        i_mret,
    output logic        o_trap_taken,
    output logic [31:0] o_mepc,
    output logic [3:0]  o_mcause,
    output logic [31:0] o_instret
);

    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_e;

    state_e        state_q, state_d;
    // PCs are stored as word addresses so alignment holds by construction
    logic [29:0]   pc_q, pc_d, mepc_q, mepc_d;
    logic [1:0]    cause_q, cause_d;
    logic [3:0]    mcause_q, mcause_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, req_d, vld_q, vld_d, trap_q, trap_d;
    logic          tmo_hit;

    assign tmo_hit = (FETCH_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mepc_d   = mepc_q;
        cause_d  = cause_q;
        mcause_d = mcause_q;
        tmo_d    = tmo_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                tmo_d = tmo_q + TW'(1);
                // ack takes precedence over a timeout expiring in the same cycle
                if (i_imem_ack) begin
                    tmo_d = '0;
                    if (i_imem_err) begin
                        state_d = TRAP;
                        cause_d = 2'd1;
                    end else begin
                        state_d = EXEC;
                    end
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    state_d = TRAP;
                    cause_d = 2'd1;
                end
            end
            EXEC: begin
                state_d = FETCH;
                if (i_illegal) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end else if (i_mret) begin
                    pc_d = mepc_q;
                end else if (i_br_taken && (i_br_target[1:0] != 2'b00)) begin
                    state_d = TRAP;
                    cause_d = 2'd0;
                end else if (i_br_taken) begin
                    pc_d = i_br_target[31:2];
                end else begin
                    pc_d = pc_q + 30'd1;
                end
            end
            TRAP: begin
                mepc_d   = pc_q;
                mcause_d = {2'b00, cause_q};
                pc_d     = TRAP_VECTOR[31:2];
                state_d  = FETCH;
            end
            default: state_d = BOOT;
        endcase
        req_d  = (state_d == FETCH);
        vld_d  = (state_d == EXEC);
        trap_d = (state_d == TRAP);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR[31:2];
            mepc_q   <= '0;
            cause_q  <= '0;
            mcause_q <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mepc_q   <= mepc_d;
            cause_q  <= cause_d;
            mcause_q <= mcause_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            trap_q   <= trap_d;
        end
    end

`ifdef PC_SEQ_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (state_q == EXEC && state_d != TRAP) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign o_instret = instret_q;
`else
    assign o_instret = 32'h0;
`endif

    assign o_pc          = {pc_q, 2'b00};
    assign o_mepc        = {mepc_q, 2'b00};
    assign o_mcause      = mcause_q;
    assign o_imem_req    = req_q;
    assign o_instr_valid = vld_q;
    assign o_trap_taken  = trap_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: per-instruction transaction model with directed and random stimulus.
module tb_pc_fetch_sequencer;

    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] o_pc;
    logic        o_imem_req;
    logic        i_imem_ack = 1'b0;
    logic        i_imem_err = 1'b0;
    logic        o_instr_valid;
    logic        i_br_taken = 1'b0;
    logic [31:0] i_br_target = '0;
    logic        i_illegal = 1'b0;
    logic        i_mret = 1'b0;
    logic        o_trap_taken;
    logic [31:0] o_mepc;
    logic [3:0]  o_mcause;
    logic [31:0] o_instret;

    pc_fetch_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_pc         (o_pc),
        .o_imem_req   (o_imem_req),
        .i_imem_ack   (i_imem_ack),
        .i_imem_err   (i_imem_err),
        .o_instr_valid(o_instr_valid),
        .i_br_taken   (i_br_taken),
        .i_br_target  (i_br_target),
        .i_illegal    (i_illegal),
        .i_mret       (i_mret),
        .o_trap_taken (o_trap_taken),
        .o_mepc       (o_mepc),
        .o_mcause     (o_mcause),
        .o_instret    (o_instret)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // architectural model state
    logic [31:0] m_pc, m_mepc, m_instret;
    logic [3:0]  m_mcause;

`ifdef PC_SEQ_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic garbage();
        i_br_taken  = 1'($urandom);
        i_illegal   = 1'($urandom);
        i_mret      = 1'($urandom);
        i_br_target = $urandom;
    endtask

    task automatic quiet();
        i_imem_ack = 0; i_imem_err = 0;
        i_br_taken = 0; i_illegal = 0; i_mret = 0; i_br_target = '0;
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, "_mepc"}, o_mepc, m_mepc);
        chk({tag, "_mcause"}, {28'h0, o_mcause}, {28'h0, m_mcause});
        chk({tag, "_instret"}, o_instret, INSTRET_ON ? m_instret : 32'h0);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH.
    task automatic run_instr(input int dly, input bit err, input bit ill, input bit mret,
                             input bit br, input logic [31:0] tgt);
        int  nf;
        bit  fault, trap;
        logic [3:0] cause;
        nf    = (dly < TMO) ? dly + 1 : TMO;
        fault = (dly >= TMO) || err;
        trap  = fault;
        cause = 4'd1;
        for (int c = 0; c < nf; c++) begin
            chk("fetch_req", {31'h0, o_imem_req}, 32'h1);
            chk("fetch_pc", o_pc, m_pc);
            chk("fetch_vld", {31'h0, o_instr_valid}, 32'h0);
            garbage();
            i_imem_ack = (c == dly);
            i_imem_err = (c == dly) && err;
            @(negedge i_clk);
        end
        quiet();
        if (!fault) begin
            chk("exec_vld", {31'h0, o_instr_valid}, 32'h1);
            chk("exec_req", {31'h0, o_imem_req}, 32'h0);
            i_imem_ack = 1'($urandom); i_imem_err = 1'($urandom);
            i_illegal = ill; i_mret = mret; i_br_taken = br; i_br_target = tgt;
            @(negedge i_clk);
            quiet();
            if (ill) begin
                trap = 1; cause = 4'd2;
            end else if (mret) begin
                m_pc = m_mepc;
            end else if (br && tgt[1:0] != 2'b00) begin
                trap = 1; cause = 4'd0;
            end else if (br) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            if (!trap) m_instret = m_instret + 32'd1;
        end
        if (trap) begin
            chk("trap_pulse", {31'h0, o_trap_taken}, 32'h1);
            chk("trap_req", {31'h0, o_imem_req}, 32'h0);
            i_imem_ack = 1'($urandom); garbage();
            @(negedge i_clk);
            quiet();
            m_mepc = m_pc; m_mcause = cause; m_pc = 32'h0000_0100;
            chk("trap_done", {31'h0, o_trap_taken}, 32'h0);
        end
        chk_arch("post");
    endtask

    task automatic seq(); run_instr(0, 0, 0, 0, 0, 0); endtask

    task automatic do_reset();
        @(negedge i_clk);
        #2 i_reset = 0;
        #1;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_req", {31'h0, o_imem_req}, 32'h0);
        chk("rst_vld", {31'h0, o_instr_valid}, 32'h0);
        chk("rst_trap", {31'h0, o_trap_taken}, 32'h0);
        chk("rst_mepc", o_mepc, 32'h0);
        chk("rst_mcause", {28'h0, o_mcause}, 32'h0);
        chk("rst_instret", o_instret, 32'h0);
        m_pc = 0; m_mepc = 0; m_mcause = 0; m_instret = 0;
        quiet();
        @(negedge i_clk);
        i_reset = 1;
        #1 chk("boot_req", {31'h0, o_imem_req}, 32'h0);
        @(negedge i_clk);
    endtask

    initial begin
        quiet();
        m_pc = 0; m_mepc = 0; m_mcause = 0; m_instret = 0;
        do_reset();

        // sequential stream 0,4,8,12
        seq(); seq(); seq();
        chk("seq_pc12", o_pc, 32'h0000_000C);

        do_reset();
        seq(); seq();
        run_instr(0, 0, 0, 0, 1, 32'h0000_0040);
        chk("br_pc40", o_pc, 32'h0000_0040);

        do_reset();
        seq(); seq();
        run_instr(0, 0, 0, 0, 1, 32'h0000_0042);
        chk("mis_mepc", o_mepc, 32'h0000_0008);
        chk("mis_pc", o_pc, 32'h0000_0100);

        // illegal beats mret and branch; then mret back
        run_instr(0, 0, 0, 0, 1, 32'h0000_0010);
        run_instr(1, 0, 1, 1, 1, 32'h0000_0080);
        chk("ill_mcause", {28'h0, o_mcause}, 32'h2);
        seq();
        run_instr(2, 0, 0, 1, 0, 0);
        chk("mret_pc", o_pc, 32'h0000_0010);

        // fetch timeout, ack on the last cycle, ack with error
        run_instr(100, 0, 0, 0, 0, 0);
        chk("tmo_mcause", {28'h0, o_mcause}, 32'h1);
        run_instr(TMO - 1, 0, 0, 0, 0, 0);
        run_instr(3, 1, 0, 0, 0, 0);

        // PC wrap
        run_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        seq();
        chk("wrap_pc", o_pc, 32'h0);

        // instret: 5 retire, illegal does not
        do_reset();
        for (int i = 0; i < 5; i++) seq();
        run_instr(0, 0, 1, 0, 0, 0);
        chk("instret5", o_instret, INSTRET_ON ? 32'd5 : 32'd0);

        // async reset in the middle of a fetch
        run_instr(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            chk("midf_req", {31'h0, o_imem_req}, 32'h1);
            @(negedge i_clk);
        end
        do_reset();

        for (int n = 0; n < 80; n++) begin
            int dly;
            bit err, ill, mr, br;
            logic [31:0] tgt;
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 30) : $urandom_range(0, 3);
            err = ($urandom_range(0, 9) == 0);
            ill = ($urandom_range(0, 9) == 0);
            mr  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 2) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            run_instr(dly, err, ill, mr, br, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the program counter of the single-cycle core.
- Sequences each fetch through a variable-latency instruction-memory handshake and issues one execute pulse per instruction.
- Selects the next PC from sequential, branch, trap and mret sources.
- Holds mepc/mcause for minimal trap support; owns the PC register and its word alignment.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry; bits [1:0] are forced to 00.
- FETCH_TIMEOUT, 16, cycles in FETCH without ack before an access fault is raised; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- o_pc  out  32  current PC (instruction address); always word-aligned.
- o_imem_req  out  1  fetch request; high throughout FETCH.
- i_imem_ack  in  1  fetch complete (instruction data valid this cycle).
- i_imem_err  in  1  access error; qualified by i_imem_ack.
- o_instr_valid  out  1  one-cycle execute/commit strobe.
- i_br_taken  in  1  branch/jump taken; sampled only when o_instr_valid=1.
- i_br_target  in  32  branch/jump target.
- i_illegal  in  1  decoder illegal-instruction flag; sampled when o_instr_valid=1.
- i_mret  in  1  mret decoded; sampled when o_instr_valid=1.
- o_trap_taken  out  1  one-cycle pulse while in TRAP.
- o_mepc  out  32  saved faulting PC.
- o_mcause  out  4  0 = misaligned target, 1 = fetch access fault, 2 = illegal instruction.
- o_instret  out  32  retired-instruction count (optional feature).

Behaviour:
- Reset (async assert, synchronous-to-clock deassert handled upstream) sets:
  - state=BOOT, o_pc=RESET_VECTOR, o_imem_req=0, o_instr_valid=0, o_trap_taken=0;
  - o_mepc=0, o_mcause=0, timeout counter=0, o_instret=0.
- Reset asserted mid-fetch or mid-trap aborts immediately to these values; no pending state survives.
- States: BOOT, FETCH, EXEC, TRAP. All outputs are registered or decoded from state only (Moore); no input-to-output combinational paths.
- BOOT: one dead cycle, then FETCH.
- FETCH: o_imem_req=1; o_pc is held stable; the timeout counter increments each cycle.
  - i_imem_ack=1 and i_imem_err=0: go to EXEC.
  - i_imem_ack=1 and i_imem_err=1: go to TRAP, pending cause=1.
  - Counter reaches FETCH_TIMEOUT-1 without ack: go to TRAP, cause=1.
  - Ack in the same cycle as timeout expiry: ack wins.
  - The counter clears on every FETCH exit.
- EXEC: o_instr_valid=1 for exactly one cycle, then FETCH (or TRAP). Next PC is chosen by priority:
  1. i_illegal: go to TRAP, cause=2, PC unchanged.
  2. i_mret: o_pc <= o_mepc.
  3. i_br_taken with i_br_target[1:0]!=0: go to TRAP, cause=0, PC unchanged.
  4. i_br_taken: o_pc <= i_br_target.
  5. Otherwise: o_pc <= o_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- TRAP: one cycle with o_trap_taken=1. On exit edge:
  - o_mepc <= o_pc (the faulting PC);
  - o_mcause <= pending cause;
  - o_pc <= TRAP_VECTOR;
  - then go to FETCH.
- Latency: a fetch acked in its first cycle gives instruction issue every 2 cycles (FETCH, EXEC). Trap entry adds 1 cycle.
- i_imem_ack, i_imem_err, i_br_taken, i_illegal and i_mret are ignored outside the states where they are sampled.

Optional Feature:
- Macro PC_SEQ_INSTRET_EN.
- Defined: o_instret increments by 1 on each EXEC cycle that does not enter TRAP; it wraps at 2^32 and resets to 0.
- Undefined: no counter logic is built; o_instret is tied to 32'h0. The port exists in both builds.

Test Plan:
- Reset release, ack in the first FETCH cycle every time: o_pc goes 0, 4, 8, 12; o_instr_valid pulses every 2nd cycle; o_imem_req low during BOOT and EXEC.
- i_br_taken=1, target 32'h0000_0040, at PC 8: next fetch PC is 0x40. Target 32'h0000_0042: TRAP; then o_mepc=8, o_mcause=0, o_pc=0x100.
- i_illegal=1 at PC 0x10 together with i_mret=1 and i_br_taken=1: illegal wins; o_mcause=2, o_mepc=0x10. A following mret at PC 0x104 returns to o_pc=0x10.
- FETCH_TIMEOUT=16, no ack: o_imem_req is high for exactly 16 cycles, then o_trap_taken pulses and o_mcause=1. Repeat with ack on cycle 16: EXEC, no trap. Repeat with ack+err: cause=1.
- PC 32'hFFFF_FFFC with a sequential instruction: next o_pc=0. Reset asserted while in FETCH: all outputs return to reset values asynchronously.
- With PC_SEQ_INSTRET_EN: 5 normal instructions plus 1 illegal give o_instret=5. Without the macro: o_instret stays 0.
